mem_stage: RTL and testbench

Memory-access pipeline stage (stage 4) of the five-stage MIPS core, directly upstream of the writeback stage. It holds one instruction from execute and waits for the data-SRAM response when a load was issued. It aligns, sign-extends and merges load data, then hands a completed instruction to writeback over a valid/allow_in handshake. It tracks and discards data responses orphaned by a writeback flush.

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_stage_if.sv | 38 +++
 rtl/mem_stage_load_align.sv | 44 ++++
 rtl/mem_stage.sv | 90 +++++++++
 tb/tb_mem_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: load encodings, FSM states and
// the per-instruction slot held between execute and writeback.
package mem_stage_pkg;

  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LBU  = 3'd2;
  localparam logic [2:0] LOAD_LH   = 3'd3;
  localparam logic [2:0] LOAD_LHU  = 3'd4;
  localparam logic [2:0] LOAD_LW   = 3'd5;
  localparam logic [2:0] LOAD_LWL  = 3'd6;
  localparam logic [2:0] LOAD_LWR  = 3'd7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0]  ex;
    logic [31:0] pc;
    logic [31:0] ctrl_info;
    logic [31:0] ctrl_info2;
    logic [4:0]  dest;
    logic [2:0]  load_op;
    logic [1:0]  off;
    logic [31:0] rt_value;
  } slot_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline link around the memory stage: execute-side inputs and the
// writeback-side outputs. The stage itself uses the slave modport.
interface mem_stage_if;
  logic        valid;
  logic        allow_in;
  logic [5:0]  ex;
  logic [31:0] pc;
  logic [31:0] ctrl_info;
  logic [31:0] ctrl_info2;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] rt_value;
  logic [2:0]  load_op;
  logic        mem_req;

  logic        next_allow_in;
  logic        valid_out;
  logic [5:0]  ex_out;
  logic [31:0] pc_out;
  logic [4:0]  dest_out;
  logic [31:0] ctrl_info_out;
  logic [31:0] ctrl_info2_out;
  logic [31:0] wb_value;

  modport master (
    output valid, ex, pc, ctrl_info, ctrl_info2, dest, alu_result, rt_value,
           load_op, mem_req, next_allow_in,
    input  allow_in, valid_out, ex_out, pc_out, dest_out, ctrl_info_out,
           ctrl_info2_out, wb_value
  );

  modport slave (
    input  valid, ex, pc, ctrl_info, ctrl_info2, dest, alu_result, rt_value,
           load_op, mem_req, next_allow_in,
    output allow_in, valid_out, ex_out, pc_out, dest_out, ctrl_info_out,
           ctrl_info2_out, wb_value
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Little-endian load alignment: byte/halfword extract with extension, and
// the LWL/LWR partial-word merges with the old rt contents.
import mem_stage_pkg::*;

module load_align (
  input  logic [2:0]  load_op,
  input  logic [1:0]  off,
  input  logic [31:0] data_rdata,
  input  logic [31:0] rt_value,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;

  assign b = data_rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? data_rdata[31:16] : data_rdata[15:0];

  always_comb begin
    result = data_rdata;
    case (load_op)
      LOAD_LB:  result = {{24{b[7]}}, b};
      LOAD_LBU: result = {24'd0, b};
      LOAD_LH:  result = {{16{h[15]}}, h};
      LOAD_LHU: result = {16'd0, h};
      LOAD_LWL: begin
        case (off)
          2'd0:    result = {data_rdata[7:0],  rt_value[23:0]};
          2'd1:    result = {data_rdata[15:0], rt_value[15:0]};
          2'd2:    result = {data_rdata[23:0], rt_value[7:0]};
          default: result = data_rdata;
        endcase
      end
      LOAD_LWR: begin
        case (off)
          2'd0:    result = data_rdata;
          2'd1:    result = {rt_value[31:24], data_rdata[31:8]};
          2'd2:    result = {rt_value[31:16], data_rdata[31:16]};
          default: result = {rt_value[31:8],  data_rdata[31:24]};
        endcase
      end
      default:  result = data_rdata;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// MIPS stage 4: holds one instruction, waits for its data-SRAM response,
// aligns the load result and hands it to writeback; discards orphaned responses.
import mem_stage_pkg::*;

module mem_stage (
  input  logic        clock,
  input  logic        reset,
  mem_stage_if.slave  bus,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        flush
);
  state_t      state, state_nxt;
  slot_t       slot;
  logic [31:0] wb_value_q;
  logic [31:0] aligned;
  logic [1:0]  drop_cnt;
  logic        eff_req, capture, resp, drop_inc, drop_dec;

  assign eff_req  = bus.mem_req && (bus.ex == 6'd0);
  assign capture  = bus.valid && bus.allow_in && !flush;
  assign drop_dec = data_data_ok && (drop_cnt != 2'd0);
  assign resp     = data_data_ok && (drop_cnt == 2'd0) && (state == WAIT);
  // A response in the flush cycle belongs to the flushed load, so nothing is orphaned.
  assign drop_inc = flush && (state == WAIT) && !(data_data_ok && (drop_cnt == 2'd0));

  load_align u_align (
    .load_op   (slot.load_op),
    .off       (slot.off),
    .data_rdata(data_rdata),
    .rt_value  (slot.rt_value),
    .result    (aligned)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (capture) state_nxt = eff_req ? WAIT : READY;
        WAIT:    if (resp) state_nxt = READY;
        READY:   if (bus.next_allow_in)
                   state_nxt = capture ? (eff_req ? WAIT : READY) : EMPTY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    bus.allow_in  = (state == EMPTY) || ((state == READY) && bus.next_allow_in);
    bus.valid_out = (state == READY);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot       <= '0;
      wb_value_q <= '0;
    end else if (capture) begin
      slot.ex         <= bus.ex;
      slot.pc         <= bus.pc;
      slot.ctrl_info  <= bus.ctrl_info;
      slot.ctrl_info2 <= bus.ctrl_info2;
      slot.dest       <= bus.dest;
      slot.load_op    <= bus.load_op;
      slot.off        <= bus.alu_result[1:0];
      slot.rt_value   <= bus.rt_value;
      wb_value_q      <= bus.alu_result;
    end else if (resp && !flush) begin
      wb_value_q <= aligned;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) drop_cnt <= 2'd0;
    else       drop_cnt <= drop_cnt + {1'b0, drop_inc} - {1'b0, drop_dec};
  end

  assign bus.ex_out         = slot.ex;
  assign bus.pc_out         = slot.pc;
  assign bus.dest_out       = slot.dest;
  assign bus.ctrl_info_out  = slot.ctrl_info;
  assign bus.ctrl_info2_out = slot.ctrl_info2;
  assign bus.wb_value       = wb_value_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against an arithmetic load model.
import mem_stage_pkg::*;

module tb_mem_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        flush;
  int          checks = 0;
  int          errors = 0;

  mem_stage_if bus ();

  mem_stage dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .flush       (flush)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load semantics as whole-word shift/mask arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rt, input logic [31:0] rd);
    int          sh;
    logic [31:0] x;
    sh = 8 * int'(addr[1:0]);
    case (op)
      3'd1: begin x = (rd >> sh) & 32'hFF; if (x[7]) x = x | 32'hFFFF_FF00; end
      3'd2: x = (rd >> sh) & 32'hFF;
      3'd3: begin x = (rd >> (addr[1] ? 16 : 0)) & 32'hFFFF; if (x[15]) x = x | 32'hFFFF_0000; end
      3'd4: x = (rd >> (addr[1] ? 16 : 0)) & 32'hFFFF;
      3'd6: x = (rd << (24 - sh)) | (rt & ((32'd1 << (24 - sh)) - 32'd1));
      3'd7: x = (rd >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
      default: x = rd;
    endcase
    return x;
  endfunction

  // One instruction through an empty stage; response `gap` cycles after capture.
  task automatic run_txn(input string tag, input logic [2:0] op, input logic req,
                         input logic [5:0] exc, input logic [31:0] alu, input logic [31:0] rt,
                         input logic [31:0] rd, input int gap, output logic [31:0] got);
    logic        is_load;
    logic [31:0] exp, tpc, tci;
    logic [4:0]  tdst;
    is_load = req && (exc == 6'd0);
    exp  = is_load ? ref_load(op, alu, rt, rd) : alu;
    tpc  = $urandom;
    tci  = $urandom;
    tdst = 5'($urandom);
    chk({tag, "_allow_in"}, bus.allow_in, 1);
    bus.valid = 1; bus.load_op = op; bus.mem_req = req; bus.ex = exc;
    bus.alu_result = alu; bus.rt_value = rt; bus.pc = tpc; bus.dest = tdst;
    bus.ctrl_info = tci; bus.ctrl_info2 = ~tci;
    step();
    bus.valid = 0; bus.mem_req = 0;
    if (is_load) begin
      chk({tag, "_wait_vo"}, bus.valid_out, 0);
      chk({tag, "_wait_ai"}, bus.allow_in, 0);
      repeat (gap - 1) step();
      data_data_ok = 1; data_rdata = rd;
      step();
      data_data_ok = 0; data_rdata = $urandom;
    end
    chk({tag, "_vo"}, bus.valid_out, 1);
    chk({tag, "_wb"}, bus.wb_value, exp);
    chk({tag, "_pc"}, bus.pc_out, tpc);
    chk({tag, "_ex"}, {26'd0, bus.ex_out}, {26'd0, exc});
    chk({tag, "_dest"}, {27'd0, bus.dest_out}, {27'd0, tdst});
    chk({tag, "_ci2"}, bus.ctrl_info2_out, ~tci);
    got = bus.wb_value;
    step();
    chk({tag, "_retired"}, bus.valid_out, 0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] vals [4];
    reset = 1; flush = 0; data_data_ok = 0; data_rdata = 0;
    bus.valid = 0; bus.ex = 0; bus.pc = 0; bus.ctrl_info = 0; bus.ctrl_info2 = 0;
    bus.dest = 0; bus.alu_result = 0; bus.rt_value = 0; bus.load_op = 0;
    bus.mem_req = 0; bus.next_allow_in = 1;

    // Reset state.
    step();
    chk("rst_vo", bus.valid_out, 0);
    chk("rst_ai", bus.allow_in, 1);
    chk("rst_wb", bus.wb_value, 0);
    chk("rst_pc", bus.pc_out, 0);
    chk("rst_drop", {30'd0, dut.drop_cnt}, 0);
    reset = 0;
    step();

    // Test-plan vectors.
    run_txn("nonload", 3'd0, 0, 0, 32'h1234_5678, 0, 0, 1, got);
    chk("nonload_val", got, 32'h1234_5678);
    run_txn("lb", 3'd1, 1, 0, 32'h0000_1003, 0, 32'h80FF_0000, 2, got);
    chk("lb_val", got, 32'hFFFF_FF80);
    run_txn("lbu", 3'd2, 1, 0, 32'h0000_1003, 0, 32'h80FF_0000, 2, got);
    chk("lbu_val", got, 32'h0000_0080);
    run_txn("lwl", 3'd6, 1, 0, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD, 1, got);
    chk("lwl_val", got, 32'hCCDD_3344);
    run_txn("lwr", 3'd7, 1, 0, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD, 3, got);
    chk("lwr_val", got, 32'h11AA_BBCC);
    run_txn("exc_ld", 3'd5, 1, 6'h0A, 32'hCAFE_0000, 0, 32'h5555_5555, 1, got);
    chk("exc_ld_val", got, 32'hCAFE_0000);

    // Back-to-back non-loads at one per cycle.
    vals[0] = 32'h1111_0000; vals[1] = 32'h2222_0004; vals[2] = 32'h3333_0008; vals[3] = 32'h4444_000C;
    for (int i = 0; i < 4; i++) begin
      bus.valid = 1; bus.load_op = 0; bus.mem_req = 0; bus.ex = 0; bus.alu_result = vals[i];
      step();
      chk("b2b_vo", bus.valid_out, 1);
      chk("b2b_wb", bus.wb_value, vals[i]);
      chk("b2b_ai", bus.allow_in, 1);
    end
    bus.valid = 0;
    step();
    chk("b2b_end", bus.valid_out, 0);

    // Stall: outputs held, input not captured.
    bus.valid = 1; bus.alu_result = 32'hABCD_0001; bus.pc = 32'h0040_0000;
    step();
    bus.next_allow_in = 0; bus.alu_result = 32'h9999_9999; bus.pc = 32'h0040_0004;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ai", bus.allow_in, 0);
      step();
      chk("stall_vo", bus.valid_out, 1);
      chk("stall_wb", bus.wb_value, 32'hABCD_0001);
      chk("stall_pc", bus.pc_out, 32'h0040_0000);
    end
    bus.next_allow_in = 1; bus.valid = 0;
    step();
    chk("stall_release", bus.valid_out, 0);

    // Stray response with nothing outstanding is ignored.
    data_data_ok = 1; data_rdata = 32'h7777_7777;
    step();
    data_data_ok = 0;
    chk("stray_vo", bus.valid_out, 0);
    chk("stray_drop", {30'd0, dut.drop_cnt}, 0);

    // Flush in WAIT, new load, orphaned response dropped first.
    bus.valid = 1; bus.load_op = 3'd5; bus.mem_req = 1; bus.alu_result = 32'h100;
    step();
    bus.valid = 0; flush = 1;
    step();
    flush = 0;
    chk("fl_vo", bus.valid_out, 0);
    chk("fl_ai", bus.allow_in, 1);
    chk("fl_drop1", {30'd0, dut.drop_cnt}, 1);
    bus.valid = 1; bus.alu_result = 32'h200;
    step();
    bus.valid = 0; bus.mem_req = 0;
    data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    step();
    chk("fl_dropped_vo", bus.valid_out, 0);
    chk("fl_drop0", {30'd0, dut.drop_cnt}, 0);
    data_rdata = 32'h0000_0042;
    step();
    data_data_ok = 0;
    chk("fl_new_vo", bus.valid_out, 1);
    chk("fl_new_wb", bus.wb_value, 32'h0000_0042);
    step();

    // Flush and response in the same cycle: response consumed, nothing orphaned.
    bus.valid = 1; bus.load_op = 3'd5; bus.mem_req = 1; bus.alu_result = 32'h300;
    step();
    bus.valid = 0; bus.mem_req = 0; flush = 1; data_data_ok = 1; data_rdata = 32'h1;
    step();
    flush = 0; data_data_ok = 0;
    chk("flok_drop", {30'd0, dut.drop_cnt}, 0);
    chk("flok_vo", bus.valid_out, 0);
    run_txn("after_flok", 3'd5, 1, 0, 32'h400, 0, 32'h0BAD_F00D, 1, got);

    // Reset in WAIT with one orphan outstanding acts without a clock edge.
    bus.valid = 1; bus.load_op = 3'd5; bus.mem_req = 1; bus.alu_result = 32'h500;
    step();
    bus.valid = 0; flush = 1;
    step();
    flush = 0; bus.valid = 1;
    step();
    bus.valid = 0; bus.mem_req = 0;
    chk("pre_rst_state", {30'd0, dut.state}, {30'd0, WAIT});
    chk("pre_rst_drop", {30'd0, dut.drop_cnt}, 1);
    reset = 1;
    #1;
    chk("async_vo", bus.valid_out, 0);
    chk("async_ai", bus.allow_in, 1);
    chk("async_state", {30'd0, dut.state}, {30'd0, EMPTY});
    chk("async_drop", {30'd0, dut.drop_cnt}, 0);
    #1 reset = 0;
    step();

    // Randomized transactions.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [5:0]  exc;
      op  = 3'($urandom_range(0, 7));
      exc = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      run_txn("rand", op, op != 3'd0, exc, $urandom, $urandom, $urandom,
              $urandom_range(1, 4), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
